// File: rtl/pipelined_adder_reg_to_reg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_reg_to_reg
//
// WIDTH-bit add/subtract with a registered operand stage and a carry chain cut
// into STAGES pipeline slices. Valid/ready handshakes on both sides; when the
// output is held, the whole pipeline stalls. No bubbles are removed.
//
// Pipeline: input register (stage 0) -> STAGES slice registers -> output
// register. A beat that is never stalled has a latency of STAGES+1 cycles.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  number of carry-chain slices (1..WIDTH, WIDTH % STAGES == 0)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle when in_valid is also high
//   a_in       operand A
//   b_in       operand B
//   sub_in     0: A + B + cin_in, 1: A - B
//   cin_in     carry-in, add mode only
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum_out    result modulo 2^WIDTH
//   carry_out  carry out of the MSB (in sub mode 1 = no borrow)
//   ovf_out    signed overflow, present only when ADDER_OVF_FLAG_EN is defined
//
// Build option
//   ADDER_OVF_FLAG_EN  adds ovf_out and its output register bit.
// -----------------------------------------------------------------------------
module pipelined_adder_reg_to_reg #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int SW = WIDTH / STAGES;  // bits per slice

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder_reg_to_reg: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    // Pipeline stage k (0..STAGES) carries the operands, the result bits
    // already produced by slices below k, and the carry into slice k.
    logic [WIDTH-1:0] a_q [0:STAGES];
    logic [WIDTH-1:0] a_d [0:STAGES];
    logic [WIDTH-1:0] b_q [0:STAGES];
    logic [WIDTH-1:0] b_d [0:STAGES];
    logic [WIDTH-1:0] r_q [0:STAGES];
    logic [WIDTH-1:0] r_d [0:STAGES];
    logic [STAGES:0]  c_q;
    logic [STAGES:0]  c_d;
    logic [STAGES:0]  valid_q;
    logic [STAGES:0]  valid_d;
    logic [SW:0]      slice;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
`ifdef ADDER_OVF_FLAG_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    logic advance;

    // A full output register that is not being consumed freezes everything.
    assign advance  = !out_valid_q | out_ready;
    assign in_ready = advance;

    // NOTE: every variable written here gets a value before any conditional
    // or loop touches it, so no path leaves a signal unassigned (no latch).
    always_comb begin
        slice   = '0;
        valid_d = {valid_q[STAGES-1:0], in_valid};

        // Stage 0: subtraction is A + ~B + 1, so fold the inversion and the
        // forced carry-in into the input register.
        a_d[0] = a_in;
        b_d[0] = sub_in ? ~b_in : b_in;
        c_d[0] = sub_in ? 1'b1 : cin_in;
        r_d[0] = '0;

        for (int k = 0; k < STAGES; k++) begin
            // SW+1 bits wide so the slice carry is kept, never truncated.
            slice = {1'b0, a_q[k][k*SW +: SW]}
                  + {1'b0, b_q[k][k*SW +: SW]}
                  + {{SW{1'b0}}, c_q[k]};
            a_d[k+1]             = a_q[k];
            b_d[k+1]             = b_q[k];
            r_d[k+1]             = r_q[k];
            r_d[k+1][k*SW +: SW] = slice[SW-1:0];
            c_d[k+1]             = slice[SW];
        end

        sum_d   = r_q[STAGES];
        carry_d = c_q[STAGES];
`ifdef ADDER_OVF_FLAG_EN
        // Operands of equal sign producing a result of the other sign.
        ovf_d   = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1])
                & (r_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);
`endif
    end

    // NOTE: the datapath registers have no reset. Their contents only matter
    // when the matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
`ifdef ADDER_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else if (advance) begin
            valid_q     <= valid_d;
            out_valid_q <= valid_q[STAGES];
            // Load results only for real beats so a drained output keeps its
            // last value instead of picking up stale pipeline contents.
            if (valid_q[STAGES]) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
`ifdef ADDER_OVF_FLAG_EN
                ovf_q   <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
`ifdef ADDER_OVF_FLAG_EN
    assign ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_reg_to_reg.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_reg_to_reg
//
// Directed bench for pipelined_adder_reg_to_reg (WIDTH=16, STAGES=4).
// The driver pushes the hand-computed result of each accepted beat into a
// queue; a monitor pops and compares whenever the DUT hands over a result.
// ovf_out is compared only when ADDER_OVF_FLAG_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_reg_to_reg;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int LAT = S + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         sub_in = 1'b0;
    logic         cin_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum_out;
    logic         carry_out;
`ifdef ADDER_OVF_FLAG_EN
    logic         ovf_out;
`endif

    pipelined_adder_reg_to_reg #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .carry_out (carry_out)
`ifdef ADDER_OVF_FLAG_EN
        ,
        .ovf_out   (ovf_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        bit           chk_lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one comparison set per handed-over result beat.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got sum 0x%0h with no beat outstanding at %0t",
                         sum_out, $time);
            end else begin
                e = sb.pop_front();
                check("sum_out", 32'(sum_out), 32'(e.sum));
                check("carry_out", 32'(carry_out), 32'(e.carry));
`ifdef ADDER_OVF_FLAG_EN
                check("ovf_out", 32'(ovf_out), 32'(e.ovf));
`endif
                if (e.chk_lat) check("latency", 32'(cyc - e.acc), 32'(LAT));
            end
        end
    end

    // Present one beat; returns #1 after the accepting edge. Expected result
    // goes into the scoreboard at the cycle the beat is accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic [W-1:0] esum, input logic ecarry,
                        input logic eovf, input bit lat);
        exp_t e;
        bit   done = 0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        sub_in   = sub;
        cin_in   = cin;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum     = esum;
                e.carry   = ecarry;
                e.ovf     = eovf;
                e.chk_lat = lat;
                e.acc     = cyc + 1;
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        bit seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got out_valid=0 for 50 cycles expected 1", name);
        end
    endtask

    initial begin : stim
        logic [W-1:0] held_sum;
        logic         held_carry;

        // 1. Reset held with in_valid asserted.
        rst      = 1'b0;
        in_valid = 1'b1;
        a_in     = 16'h1234;
        b_in     = 16'h1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum_out", 32'(sum_out), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
`ifdef ADDER_OVF_FLAG_EN
        check("rst_ovf_out", 32'(ovf_out), 32'd0);
`endif
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 2. Add with carry ripple through every slice.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        send(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);

        // 3. Subtract; cin_in must be ignored in sub mode.
        send(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1);
        repeat (10) @(posedge clk);
        #1;

        // 4. Eight back-to-back beats, out_ready held high.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1);
        send(16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1);
        send(16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1);
        send(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        send(16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1);
        repeat (10) @(posedge clk);
        #1;

        // 5. Output stall mid-stream.
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 0);
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 0);
        out_ready = 1'b0;
        fork
            begin
                send(16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0, 0);
                send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
                send(16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0);
                send(16'h00F0, 16'h000F, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 0);
                send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
            end
            begin
                wait_out_valid("stall_out_valid");
                held_sum   = sum_out;
                held_carry = carry_out;
                check("stall_first_sum", 32'(held_sum), 32'h0002);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_out_valid_held", 32'(out_valid), 32'd1);
                    check("stall_sum_stable", 32'(sum_out), 32'(held_sum));
                    check("stall_carry_stable", 32'(carry_out), 32'(held_carry));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (15) @(posedge clk);
        #1;
        check("stall_drained", 32'(sb.size()), 32'd0);

        // 6. Reset with three beats in flight.
        send(16'h0101, 16'h0101, 1'b0, 1'b0, 16'h0202, 1'b0, 1'b0, 0);
        send(16'h0202, 16'h0202, 1'b0, 1'b0, 16'h0404, 1'b0, 1'b0, 0);
        send(16'h0303, 16'h0303, 1'b0, 1'b0, 16'h0606, 1'b0, 1'b0, 0);
        out_ready = 1'b0;
        wait_out_valid("pre_reset_out_valid");
        #2;
        rst = 1'b0;
        #1;
        check("reset_drop_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_sum_out", 32'(sum_out), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("no_ghost_beat", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1);

        // Drain and make sure every accepted beat came out.
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
